// File: rtl/network_led_pkg.sv
// rtl/network_led_pkg.sv - shared LED mode/state types and prescaler helper for network_led_ctrl
package network_led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_ACT   = 2'b11
  } led_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FLASH = 2'b01,
    HOLD  = 2'b10
  } act_state_t;

  function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/network_led_ctrl_if.sv
// rtl/network_led_ctrl_if.sv - per-channel link between the shared timebase and one activity FSM
interface network_led_ctrl_if;
  logic tick;
  logic enable;
  logic act;
  logic lit;

  modport master (output tick, output enable, output act, input lit);
  modport slave  (input tick, input enable, input act, output lit);
endinterface

// File: rtl/network_led_act_fsm.sv
// rtl/network_led_act_fsm.sv - port-activity flicker FSM for one LED channel (IDLE lit, FLASH dark, HOLD lit)
module network_led_act_fsm
  import network_led_pkg::*;
#(
  parameter int STRETCH_TICKS = 50
) (
  input logic              clk_i,
  input logic              rst_i,
  network_led_ctrl_if.slave ch
);

  localparam int CW = $clog2(STRETCH_TICKS + 1);
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH_TICKS);
  localparam logic [CW-1:0] LAST   = CW'(1);

  act_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (!ch.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ch.act) begin
            state_d = FLASH;
            cnt_d   = RELOAD;
          end
        end
        FLASH: begin
          if (ch.act) pend_d = 1'b1;
          if (ch.tick) begin
            if (cnt_q == LAST) begin
              state_d = HOLD;
              cnt_d   = RELOAD;
            end else begin
              cnt_d = cnt_q - LAST;
            end
          end
        end
        HOLD: begin
          if (ch.tick && cnt_q == LAST) begin
            // an event landing on the exit tick still earns another flash
            state_d = (pend_q || ch.act) ? FLASH : IDLE;
            cnt_d   = RELOAD;
            pend_d  = 1'b0;
          end else begin
            if (ch.act) pend_d = 1'b1;
            if (ch.tick) cnt_d = cnt_q - LAST;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  assign ch.lit = (state_q != FLASH);

endmodule

// File: rtl/network_led_ctrl.sv
// rtl/network_led_ctrl.sv - multi-channel LED controller: shared prescaler/blink phase, per-channel mode mux.
// Optional brightness PWM gate enabled by NETWORK_LED_DIM_EN.
module network_led_ctrl
  import network_led_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int CLK_HZ        = 50000000,
  parameter int TICK_HZ       = 1000,
  parameter int BLINK_TICKS   = 250,
  parameter int STRETCH_TICKS = 50
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   act_i,
`ifdef NETWORK_LED_DIM_EN
  input  logic [3:0]          bright_i,
`endif
  output logic [NUM_CH-1:0]   LEDG,
  output logic                tick_o
);

  localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
  localparam int PW       = $clog2(TICK_DIV);
  localparam int BW       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [BW-1:0]     blink_q, blink_d;
  logic              phase_q, phase_d;
  logic [NUM_CH-1:0] ledg_q, ledg_d;
  logic [NUM_CH-1:0] lit_w;

  always_comb begin
    presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_q == PW'(TICK_DIV - 1));
    blink_d = blink_q;
    phase_d = phase_q;
    if (tick_q) begin
      if (blink_q == BW'(BLINK_TICKS - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    network_led_ctrl_if ch_if ();

    assign ch_if.tick   = tick_q;
    assign ch_if.enable = (led_mode_t'(mode_i[2*g +: 2]) == LED_ACT);
    assign ch_if.act    = act_i[g];
    assign lit_w[g]     = ch_if.lit;

    network_led_act_fsm #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) u_fsm (
      .clk_i(CLOCK_50),
      .rst_i(RESET),
      .ch   (ch_if.slave)
    );
  end

`ifdef NETWORK_LED_DIM_EN
  logic [3:0] pwm_q;
  logic       pwm_on;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) pwm_q <= '0;
    else       pwm_q <= pwm_q + 4'd1;
  end

  assign pwm_on = (pwm_q <= bright_i);
`else
  logic pwm_on;
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    ledg_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (led_mode_t'(mode_i[2*i +: 2]))
        LED_OFF:   ledg_d[i] = 1'b0;
        LED_ON:    ledg_d[i] = pwm_on;
        LED_BLINK: ledg_d[i] = phase_q & pwm_on;
        LED_ACT:   ledg_d[i] = lit_w[i] & pwm_on;
        default:   ledg_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      blink_q <= '0;
      phase_q <= 1'b0;
      ledg_q  <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      ledg_q  <= ledg_d;
    end
  end

  assign LEDG   = ledg_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_network_led_ctrl.sv
// tb/tb_network_led_ctrl.sv - directed self-checking bench for network_led_ctrl (NETWORK_LED_DIM_EN optional)
module tb_network_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mode;
  logic [3:0] act;
  logic [3:0] ledg;
  logic       tick;
`ifdef NETWORK_LED_DIM_EN
  logic [3:0] bright;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n        = 0;

  always #5 clk = ~clk;

  network_led_ctrl #(
    .NUM_CH(4), .CLK_HZ(1000), .TICK_HZ(100), .BLINK_TICKS(3), .STRETCH_TICKS(2)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .mode_i  (mode),
    .act_i   (act),
`ifdef NETWORK_LED_DIM_EN
    .bright_i(bright),
`endif
    .LEDG    (ledg),
    .tick_o  (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk(input int k);
    repeat (k) @(negedge clk);
    n += k;
  endtask

  initial begin
    int run;
    int dark_runs;
    int highs;
    rst  = 1'b1;
    mode = 8'b00_00_00_01;
    act  = 4'b0;
`ifdef NETWORK_LED_DIM_EN
    bright = 4'd15;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ledg", {28'b0, ledg}, 32'h0);
      check("reset_tick", {31'b0, tick}, 32'h0);
    end

    // ch0 ON, ch1 OFF, ch2 BLINK, ch3 OFF
    rst  = 1'b0;
    mode = 8'b00_10_00_01;
    tk(1);
    check("on_ch0", {31'b0, ledg[0]}, 32'h1);
    check("off_ch1", {31'b0, ledg[1]}, 32'h0);
    check("blink_init", {31'b0, ledg[2]}, 32'h0);
    tk(8);  check("tick_n9", {31'b0, tick}, 32'h0);
    tk(1);  check("tick_n10", {31'b0, tick}, 32'h1);
    tk(1);  check("tick_n11", {31'b0, tick}, 32'h0);
    tk(9);  check("tick_n20", {31'b0, tick}, 32'h1);
    tk(11); check("blink_n31", {31'b0, ledg[2]}, 32'h0);
    tk(1);  check("blink_n32", {31'b0, ledg[2]}, 32'h1);
    tk(29); check("blink_n61", {31'b0, ledg[2]}, 32'h1);
    tk(1);  check("blink_n62", {31'b0, ledg[2]}, 32'h0);

    // single act pulse just after the tick processed at n=71
    mode[7:6] = 2'b11;
    tk(1);  check("act_idle_lit", {31'b0, ledg[3]}, 32'h1);
    tk(8);  act[3] = 1'b1;
    tk(1);  act[3] = 1'b0;
    tk(1);  check("flash_start", {31'b0, ledg[3]}, 32'h0);
    tk(18); check("flash_end", {31'b0, ledg[3]}, 32'h0);
    tk(1);  check("hold_start", {31'b0, ledg[3]}, 32'h1);
    tk(8);  check("hold_mid", {31'b0, ledg[3]}, 32'h1);
    tk(11); check("idle_after", {31'b0, ledg[3]}, 32'h1);
    tk(19); check("no_reflash", {31'b0, ledg[3]}, 32'h1);

    // continuous traffic n=130..330: every dark phase 11..20 cycles, six flashes total
    act[3]    = 1'b1;
    run       = 0;
    dark_runs = 0;
    while (n < 400) begin
      tk(1);
      if (n == 330) act[3] = 1'b0;
      if (ledg[3] == 1'b0) begin
        run++;
      end else if (run > 0) begin
        dark_runs++;
        check("dark_len_ok", {31'b0, (run >= 11 && run <= 20)}, 32'h1);
        run = 0;
      end
    end
    check("dark_runs", dark_runs, 32'd6);
    check("act_end_lit", {31'b0, ledg[3]}, 32'h1);

    // mode OFF during FLASH with pending set, then back to ACT
    tk(1);  act[3] = 1'b1;
    tk(2);  act[3] = 1'b0;
    tk(1);  check("flash2_dark", {31'b0, ledg[3]}, 32'h0);
    mode[7:6] = 2'b00;
    tk(1);  check("off_dark", {31'b0, ledg[3]}, 32'h0);
    mode[7:6] = 2'b11;
    tk(1);  check("reenter_idle", {31'b0, ledg[3]}, 32'h1);
    run = 0;
    for (int i = 0; i < 50; i++) begin
      tk(1);
      if (ledg[3] == 1'b0) run++;
    end
    check("pending_cleared", run, 32'd0);

`ifdef NETWORK_LED_DIM_EN
    bright = 4'd3;
    tk(1);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tk(1);
      if (ledg[0]) highs++;
    end
    check("dim3_duty", highs, 32'd4);
    bright = 4'd15;
    tk(1);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tk(1);
      if (ledg[0]) highs++;
    end
    check("dim15_duty", highs, 32'd16);
`else
    highs = 0;
`endif

    // reset mid-operation
    rst = 1'b1;
    tk(1);
    check("midreset_ledg", {28'b0, ledg}, 32'h0);
    check("midreset_tick", {31'b0, tick}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
